// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array edge blocks (feeder and collector).
package systolic_pkg;

  // Default width of one value and number of values per wide word.
  localparam int DATA_W    = 8;
  localparam int NUM_WORDS = 7;

  // Wide assembled word and a single narrow lane.
  typedef logic [DATA_W*NUM_WORDS-1:0] word_t;
  typedef logic [DATA_W-1:0]           lane_t;

endpackage : systolic_pkg

// File: rtl/data_collector_if.sv
// Narrow-in / wide-out handshake bundle of the data collector.
// The slave modport is the collector's view; the master modport is its environment.
interface data_collector_if #(
  parameter int DATA_W    = systolic_pkg::DATA_W,
  parameter int NUM_WORDS = systolic_pkg::NUM_WORDS
);

  localparam int CNT_W = $clog2(NUM_WORDS);

  logic                        clear;
  logic                        enable;
  logic [DATA_W-1:0]           data_in;
  logic                        in_ready;
  logic [DATA_W*NUM_WORDS-1:0] data_out;
  logic                        out_valid;
  logic                        out_ack;
  logic [CNT_W-1:0]            fill_count;

  modport master (
    output clear,
    output enable,
    output data_in,
    output out_ack,
    input  in_ready,
    input  data_out,
    input  out_valid,
    input  fill_count
  );

  modport slave (
    input  clear,
    input  enable,
    input  data_in,
    input  out_ack,
    output in_ready,
    output data_out,
    output out_valid,
    output fill_count
  );

endinterface : data_collector_if

// File: rtl/data_collector.sv
// Byte-to-word deserializer: packs NUM_WORDS narrow values into one wide word,
// first value in the most significant lane, with a one-word output buffer so
// assembly of the next word overlaps the consumer taking the current one.
module data_collector #(
  parameter int DATA_W    = systolic_pkg::DATA_W,
  parameter int NUM_WORDS = systolic_pkg::NUM_WORDS
) (
  input  logic             clk,
  input  logic             reset,
  data_collector_if.slave  bus
);

  localparam int WORD_W = DATA_W * NUM_WORDS;
  localparam int CNT_W  = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  logic [WORD_W-1:0] asm_r;
  logic [CNT_W-1:0]  fill_r;
  logic [WORD_W-1:0] dout_r;
  logic              valid_r;

  logic [WORD_W-1:0] asm_nxt_s;
  logic [CNT_W-1:0]  fill_nxt_s;
  logic [WORD_W-1:0] dout_nxt_s;
  logic              valid_nxt_s;

  logic              last_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              complete_s;
  logic [WORD_W-1:0] shifted_s;

  // The final lane may only enter while the output buffer is free or being freed.
  assign last_s     = (fill_r == LAST_IDX);
  assign in_ready_s = !(last_s && valid_r && !bus.out_ack);
  assign accept_s   = bus.enable && in_ready_s;
  assign complete_s = accept_s && last_s;
  assign shifted_s  = {asm_r[WORD_W-DATA_W-1:0], bus.data_in};

  // Next-state for assembly register, fill counter and output buffer.
  always_comb begin
    asm_nxt_s   = asm_r;
    fill_nxt_s  = fill_r;
    dout_nxt_s  = dout_r;
    valid_nxt_s = valid_r;
    if (bus.clear) begin
      asm_nxt_s   = {WORD_W{1'b0}};
      fill_nxt_s  = {CNT_W{1'b0}};
      dout_nxt_s  = {WORD_W{1'b0}};
      valid_nxt_s = 1'b0;
    end else begin
      if (complete_s) begin
        asm_nxt_s   = {WORD_W{1'b0}};
        fill_nxt_s  = {CNT_W{1'b0}};
        dout_nxt_s  = shifted_s;
        valid_nxt_s = 1'b1;
      end else if (accept_s) begin
        asm_nxt_s  = shifted_s;
        fill_nxt_s = fill_r + CNT_W'(1);
        if (valid_r && bus.out_ack) begin
          valid_nxt_s = 1'b0;
        end else begin
          valid_nxt_s = valid_r;
        end
      end else begin
        if (valid_r && bus.out_ack) begin
          valid_nxt_s = 1'b0;
        end else begin
          valid_nxt_s = valid_r;
        end
      end
    end
  end

  // State registers; asynchronous reset discards any partial or pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      asm_r   <= {WORD_W{1'b0}};
      fill_r  <= {CNT_W{1'b0}};
      dout_r  <= {WORD_W{1'b0}};
      valid_r <= 1'b0;
    end else begin
      asm_r   <= asm_nxt_s;
      fill_r  <= fill_nxt_s;
      dout_r  <= dout_nxt_s;
      valid_r <= valid_nxt_s;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.data_out   = dout_r;
  assign bus.out_valid  = valid_r;
  assign bus.fill_count = fill_r;

endmodule : data_collector

// File: tb/tb_data_collector.sv
// Directed self-checking bench for data_collector (DATA_W=8, NUM_WORDS=7).
module tb_data_collector;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  data_collector_if #(.DATA_W(8), .NUM_WORDS(7)) bus ();

  data_collector #(.DATA_W(8), .NUM_WORDS(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    bus.enable  = 1'b1;
    bus.data_in = v;
    tick();
    bus.enable  = 1'b0;
  endtask

  task automatic ack_once();
    bus.out_ack = 1'b1;
    tick();
    bus.out_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    checks++; if (bus.data_out !== 56'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", bus.data_out, 56'h0); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", bus.fill_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 7; i++) begin
      bus.enable  = 1'b1;
      bus.data_in = 8'((i + 1) * 8'h11);
      tick();
      if (i < 6) begin
        checks++; if (bus.fill_count !== 3'(i + 1)) begin errors++; $display("FAIL basic_fill: got %0d expected %0d", bus.fill_count, i + 1); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0 at value %0d", bus.out_valid, i + 1); end
      end
    end
    bus.enable = 1'b0;
    checks++; if (bus.data_out !== 56'h11223344556677) begin errors++; $display("FAIL basic_data: got %h expected %h", bus.data_out, 56'h11223344556677); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.out_valid); end
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL basic_fill_wrap: got %0d expected 0", bus.fill_count); end
    ack_once();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_ack_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.data_out !== 56'h11223344556677) begin errors++; $display("FAIL basic_ack_hold: got %h expected %h", bus.data_out, 56'h11223344556677); end
  endtask

  task automatic test_gapped();
    logic [7:0] vals [7];
    vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07};
    for (int i = 0; i < 7; i++) begin
      push(vals[i]);
      if (i < 6) begin
        checks++; if (bus.fill_count !== 3'(i + 1)) begin errors++; $display("FAIL gap_fill: got %0d expected %0d", bus.fill_count, i + 1); end
        tick();
        checks++; if (bus.fill_count !== 3'(i + 1)) begin errors++; $display("FAIL gap_hold: got %0d expected %0d", bus.fill_count, i + 1); end
      end
    end
    checks++; if (bus.data_out !== 56'hA1B2C3D4E5F607) begin errors++; $display("FAIL gap_data: got %h expected %h", bus.data_out, 56'hA1B2C3D4E5F607); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", bus.out_valid); end
    ack_once();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 7; i++) push(8'(i + 1));
    checks++; if (bus.data_out !== 56'h01020304050607) begin errors++; $display("FAIL bp_word1: got %h expected %h", bus.data_out, 56'h01020304050607); end
    for (int i = 0; i < 6; i++) push(8'(8'h81 + i));
    checks++; if (bus.fill_count !== 3'd6) begin errors++; $display("FAIL bp_fill6: got %0d expected 6", bus.fill_count); end
    bus.enable  = 1'b1;
    bus.data_in = 8'h87;
    bus.out_ack = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", bus.in_ready); end
    tick();
    checks++; if (bus.data_out !== 56'h01020304050607) begin errors++; $display("FAIL bp_hold_word1: got %h expected %h", bus.data_out, 56'h01020304050607); end
    checks++; if (bus.fill_count !== 3'd6) begin errors++; $display("FAIL bp_stall_fill: got %0d expected 6", bus.fill_count); end
    bus.out_ack = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ack_ready: got %b expected 1", bus.in_ready); end
    tick();
    bus.enable  = 1'b0;
    bus.out_ack = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_kept: got %b expected 1", bus.out_valid); end
    checks++; if (bus.data_out !== 56'h81828384858687) begin errors++; $display("FAIL bp_word2: got %h expected %h", bus.data_out, 56'h81828384858687); end
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL bp_fill0: got %0d expected 0", bus.fill_count); end
    ack_once();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_streaming();
    bus.out_ack = 1'b1;
    for (int i = 0; i < 14; i++) begin
      bus.enable  = 1'b1;
      bus.data_in = 8'(8'h20 + i);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready: got %b expected 1 at value %0d", bus.in_ready, i + 1); end
      tick();
      checks++; if (bus.out_valid !== ((i == 6) || (i == 13))) begin errors++; $display("FAIL stream_valid: got %b expected %b after value %0d", bus.out_valid, ((i == 6) || (i == 13)), i + 1); end
      if (i == 6) begin
        checks++; if (bus.data_out !== 56'h20212223242526) begin errors++; $display("FAIL stream_word1: got %h expected %h", bus.data_out, 56'h20212223242526); end
      end
      if (i == 13) begin
        checks++; if (bus.data_out !== 56'h2728292A2B2C2D) begin errors++; $display("FAIL stream_word2: got %h expected %h", bus.data_out, 56'h2728292A2B2C2D); end
      end
    end
    bus.enable = 1'b0;
    tick();
    bus.out_ack = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_clear();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    checks++; if (bus.fill_count !== 3'd3) begin errors++; $display("FAIL clr_pre_fill: got %0d expected 3", bus.fill_count); end
    bus.clear   = 1'b1;
    bus.enable  = 1'b1;
    bus.data_in = 8'h44;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL clr_ready: got %b expected 1", bus.in_ready); end
    tick();
    bus.clear  = 1'b0;
    bus.enable = 1'b0;
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL clr_fill: got %0d expected 0", bus.fill_count); end
    checks++; if (bus.data_out !== 56'h0) begin errors++; $display("FAIL clr_data: got %h expected 0", bus.data_out); end
    for (int i = 0; i < 7; i++) push(8'(8'h50 + i));
    checks++; if (bus.data_out !== 56'h50515253545556) begin errors++; $display("FAIL clr_next_word: got %h expected %h", bus.data_out, 56'h50515253545556); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clr_next_valid: got %b expected 1", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    push(8'h61);
    push(8'h62);
    checks++; if (bus.fill_count !== 3'd2) begin errors++; $display("FAIL ar_pre_fill: got %0d expected 2", bus.fill_count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.data_out !== 56'h0) begin errors++; $display("FAIL ar_data: got %h expected 0", bus.data_out); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.fill_count !== 3'd0) begin errors++; $display("FAIL ar_fill: got %0d expected 0", bus.fill_count); end
    #10 reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b expected 1", bus.in_ready); end
    for (int i = 0; i < 7; i++) push(8'(8'h71 + i));
    checks++; if (bus.data_out !== 56'h71727374757677) begin errors++; $display("FAIL ar_restart: got %h expected %h", bus.data_out, 56'h71727374757677); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ar_restart_valid: got %b expected 1", bus.out_valid); end
  endtask

  // Test sequence.
  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.clear   = 1'b0;
    bus.enable  = 1'b0;
    bus.data_in = 8'h00;
    bus.out_ack = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_backpressure();
    test_streaming();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_data_collector
